// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: load-use detection, multi-cycle result
// scoreboard, structural stall and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_AW       = 5,
    parameter int LAT_W        = 3,
    parameter int MC_PIPELINED = 0,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic                   id_rs1_used,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_rs2_used,
    input  logic                   id_rs2_late,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_is_mc,
    input  logic [LAT_W-1:0]       id_mc_lat,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [REG_AW-1:0]      ex_rd,
    input  logic                   flush,
    output logic                   id_stall,
    output logic [1:0]             stall_cause,
    output logic [2**REG_AW-1:0]   busy_mask,
    output logic [CNT_W-1:0]       stall_cycles
);

    localparam int NREG = 2**REG_AW;
    localparam bit MC_SERIAL = (MC_PIPELINED == 0);

    // cnt[r] = cycles still blocking after the current one; the ID
    // stage L cycles after issue must see zero, so issue loads L-1.
    logic [LAT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  busy;
    logic             load_use;
    logic             sb_hit;
    logic             mc_struct;
    logic             issue;
    logic [LAT_W-1:0] lat_m1;

    // Pending-result vector; x0 is never tracked.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NREG; r++) begin
            busy[r] = (cnt[r] != '0);
        end
    end

    assign busy_mask = busy;

    assign load_use = id_valid & ex_valid & ex_is_load
                    & (ex_rd != '0)
                    & ((id_rs1_used & (ex_rd == id_rs1))
                     | (id_rs2_used & ~id_rs2_late
                        & (ex_rd == id_rs2)));

    assign sb_hit = id_valid
                  & ((id_rs1_used & busy[id_rs1])
                   | (id_rs2_used & busy[id_rs2])
                   | ((id_rd != '0) & busy[id_rd]));

    assign mc_struct = id_valid & id_is_mc & MC_SERIAL & (|busy);

    // Stall and cause with fixed priority; a squashed ID never stalls.
    always_comb begin
        id_stall    = 1'b0;
        stall_cause = 2'd0;
        if (!flush) begin
            if (load_use) begin
                id_stall    = 1'b1;
                stall_cause = 2'd1;
            end else if (sb_hit) begin
                id_stall    = 1'b1;
                stall_cause = 2'd2;
            end else if (mc_struct) begin
                id_stall    = 1'b1;
                stall_cause = 2'd3;
            end
        end
    end

    assign issue = id_valid & id_is_mc & ~id_stall & ~flush
                 & (id_rd != '0) & (id_mc_lat != '0);

    assign lat_m1 = id_mc_lat - LAT_W'(1);

    // Countdown per register; a new issue overrides the decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && (id_rd == REG_AW'(r))) begin
                    cnt[r] <= lat_m1;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    // Saturating stall-cycle counter for the perf CSRs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (id_stall && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: serial and pipelined instances driven
// in parallel and checked against a ready-time reference model.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int LW = 3;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic          id_rs1_used;
    logic [AW-1:0] id_rs2;
    logic          id_rs2_used;
    logic          id_rs2_late;
    logic [AW-1:0] id_rd;
    logic          id_is_mc;
    logic [LW-1:0] id_mc_lat;
    logic          ex_valid;
    logic          ex_is_load;
    logic [AW-1:0] ex_rd;
    logic          flush;

    logic          s0, s1;
    logic [1:0]    c0, c1;
    logic [NR-1:0] m0, m1;
    logic [4:0]    sc0;
    logic [5:0]    sc1;

    hazard_scoreboard #(
        .REG_AW(AW), .LAT_W(LW), .MC_PIPELINED(0), .CNT_W(5)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rs2_late(id_rs2_late), .id_rd(id_rd),
        .id_is_mc(id_is_mc), .id_mc_lat(id_mc_lat),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .flush(flush), .id_stall(s0),
        .stall_cause(c0), .busy_mask(m0), .stall_cycles(sc0)
    );

    hazard_scoreboard #(
        .REG_AW(AW), .LAT_W(LW), .MC_PIPELINED(1), .CNT_W(6)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
        .id_rs2(id_rs2), .id_rs2_used(id_rs2_used),
        .id_rs2_late(id_rs2_late), .id_rd(id_rd),
        .id_is_mc(id_is_mc), .id_mc_lat(id_mc_lat),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .flush(flush), .id_stall(s1),
        .stall_cause(c1), .busy_mask(m1), .stall_cycles(sc1)
    );

    always #5 clk = ~clk;

    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    // ready[i][r]: first cycle in which r's result is usable in ID
    longint ready [2][NR];
    longint scnt [2];
    longint smax [2] = '{31, 63};
    int     pipe [2] = '{0, 1};

    function automatic bit mbusy(int i, int r);
        return (r != 0) && (cyc < ready[i][r]);
    endfunction

    function automatic void meval(int i, output bit st,
                                  output logic [1:0] cs);
        bit lu, sb, ms, any;
        any = 1'b0;
        for (int r = 0; r < NR; r++) any |= mbusy(i, r);
        lu = id_valid && ex_valid && ex_is_load && ex_rd != 0 &&
             ((id_rs1_used && ex_rd == id_rs1) ||
              (id_rs2_used && !id_rs2_late && ex_rd == id_rs2));
        sb = id_valid &&
             ((id_rs1_used && mbusy(i, int'(id_rs1))) ||
              (id_rs2_used && mbusy(i, int'(id_rs2))) ||
              (id_rd != 0 && mbusy(i, int'(id_rd))));
        ms = id_valid && id_is_mc && pipe[i] == 0 && any;
        st = !flush && (lu || sb || ms);
        cs = !st ? 2'd0 : lu ? 2'd1 : sb ? 2'd2 : 2'd3;
    endfunction

    function automatic logic [NR-1:0] mmask(int i);
        logic [NR-1:0] v;
        for (int r = 0; r < NR; r++) v[r] = mbusy(i, r);
        return v;
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %0h want %0h",
                     nm, cyc, act, exp);
        end
    endtask

    // compare both instances with the model
    task automatic settle();
        bit st;
        logic [1:0] cs;
        #1;
        meval(0, st, cs);
        chk("u0 stall", longint'(s0), longint'(st));
        chk("u0 cause", longint'(c0), longint'(cs));
        chk("u0 mask", longint'(m0), longint'(mmask(0)));
        chk("u0 cnt", longint'(sc0), scnt[0]);
        meval(1, st, cs);
        chk("u1 stall", longint'(s1), longint'(st));
        chk("u1 cause", longint'(c1), longint'(cs));
        chk("u1 mask", longint'(m1), longint'(mmask(1)));
        chk("u1 cnt", longint'(sc1), scnt[1]);
    endtask

    task automatic adv();
        bit st [2];
        logic [1:0] cs;
        meval(0, st[0], cs);
        meval(1, st[1], cs);
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (st[i] && scnt[i] < smax[i]) scnt[i]++;
                if (id_valid && id_is_mc && !st[i] && !flush &&
                    id_rd != 0 && id_mc_lat != 0)
                    ready[i][id_rd] = cyc + longint'(id_mc_lat);
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic mclear();
        for (int i = 0; i < 2; i++) begin
            scnt[i] = 0;
            for (int r = 0; r < NR; r++) ready[i][r] = 0;
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs1_used = 0;
        id_rs2 = 0; id_rs2_used = 0; id_rs2_late = 0;
        id_rd = 0; id_is_mc = 0; id_mc_lat = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; flush = 0;
    endtask

    task automatic mc(int rd, int lat);
        idle();
        id_valid = 1; id_is_mc = 1;
        id_rd = AW'(rd); id_mc_lat = LW'(lat);
    endtask

    task automatic ldx5();
        ex_valid = 1; ex_is_load = 1; ex_rd = 5;
    endtask

    initial begin
        mclear();
        idle();
        rst_n = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst stall", longint'(s0), 0);
        chk("rst mask", longint'(m1), 0);
        chk("rst cnt", longint'(sc0), 0);
        rst_n = 1;
        @(negedge clk);

        // load-use on rs1
        idle(); ldx5();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        id_rs2 = 1; id_rs2_used = 1; id_rd = 6;
        settle();
        chk("t1 stall", longint'(s0), 1);
        chk("t1 cause", longint'(c0), 1);
        adv();
        ex_valid = 0;
        settle();
        chk("t1 bubble", longint'(s0), 0);
        adv();

        // store data resolves late, address does not
        idle(); ldx5();
        id_valid = 1; id_rs1 = 2; id_rs1_used = 1;
        id_rs2 = 5; id_rs2_used = 1; id_rs2_late = 1;
        settle();
        chk("t2 late", longint'(s0), 0);
        adv();
        id_rs1 = 5;
        settle();
        chk("t2 rs1", longint'(s0), 1);
        adv();

        // x0 never hazards
        idle();
        ex_valid = 1; ex_is_load = 1; ex_rd = 0;
        id_valid = 1; id_rs1_used = 1; id_rs2_used = 1;
        settle();
        chk("x0", longint'(s0), 0);
        adv();

        // mul x7 lat 3: consumers stall for two cycles
        mc(7, 3);
        id_rs1 = 1; id_rs1_used = 1;
        step();
        idle();
        id_valid = 1; id_rs1 = 7; id_rs1_used = 1; id_rd = 10;
        settle();
        chk("t3 +1 stall", longint'(s0), 1);
        chk("t3 +1 cause", longint'(c0), 2);
        chk("t3 +1 busy", longint'(m0[7]), 1);
        adv();
        settle();
        chk("t3 +2 stall", longint'(s1), 1);
        adv();
        settle();
        chk("t3 +3 stall", longint'(s0), 0);
        chk("t3 +3 busy", longint'(m0[7]), 0);
        adv();

        // structural stall only on the serial instance
        mc(7, 4);
        step();
        mc(8, 2);
        settle();
        chk("t4 cause", longint'(c0), 3);
        chk("t4 pipe", longint'(s1), 0);
        adv();
        settle();
        chk("t4 both", longint'(m1[8:7]), 3);
        chk("t4 hold", longint'(c0), 3);
        adv();
        step();
        settle();
        chk("t4 free", longint'(s0), 0);
        adv();
        idle();
        repeat (4) step();

        // WAW against a count of one, then reissue
        mc(9, 2);
        step();
        settle();
        chk("t5 waw", longint'(s0), 1);
        chk("t5 cause", longint'(c0), 2);
        adv();
        settle();
        chk("t5 go", longint'(s0), 0);
        adv();
        idle();
        settle();
        chk("t5 busy", longint'(m0[9]), 1);
        adv();
        settle();
        chk("t5 clr", longint'(m0[9]), 0);
        adv();

        // flush wins over stall and blocks issue
        mc(11, 3); ldx5();
        id_rs1 = 5; id_rs1_used = 1; flush = 1;
        settle();
        chk("t6 flush", longint'(s0), 0);
        chk("t6 fcause", longint'(c0), 0);
        adv();
        idle();
        settle();
        chk("t6 noissue", longint'(m1[11]), 0);
        adv();

        // three pending entries then async reset
        for (int r = 1; r <= 3; r++) begin
            mc(r, 7);
            step();
        end
        idle();
        settle();
        chk("t6 three", longint'(m1[3:1]), 7);
        rst_n = 0;
        #1;
        chk("t6 rmask1", longint'(m1), 0);
        chk("t6 rmask0", longint'(m0), 0);
        chk("t6 rcnt", longint'(sc1), 0);
        mclear();
        adv();
        rst_n = 1;
        @(negedge clk);

        // saturation: 40 stalled cycles
        idle(); ldx5();
        id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
        repeat (40) step();
        settle();
        chk("sat u0", longint'(sc0), 31);
        chk("sat u1", longint'(sc1), 40);
        adv();

        // randomized traffic on a small register window
        for (int n = 0; n < 3000; n++) begin
            id_valid    = ($urandom_range(9) < 8);
            id_rs1      = AW'($urandom_range(7));
            id_rs1_used = 1'($urandom);
            id_rs2      = AW'($urandom_range(7));
            id_rs2_used = 1'($urandom);
            id_rs2_late = ($urandom_range(3) == 0);
            id_rd       = AW'($urandom_range(7));
            id_is_mc    = ($urandom_range(9) < 3);
            id_mc_lat   = LW'($urandom_range(7));
            ex_valid    = 1'($urandom);
            ex_is_load  = 1'($urandom);
            ex_rd       = AW'($urandom_range(7));
            flush       = ($urandom_range(9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
